// File: rtl/mat_stream_tx.sv
// mat_stream_tx: walks a ROWS x COLS result memory in row-major order, splits
// each DATA_W-bit element into DATA_W/8 bytes and hands them one at a time to
// a byte-wide UART transmitter. An optional header byte precedes the data.
//
// Ports:
//   slow_clk     clock
//   rst          asynchronous, active-high reset
//   start        level request; a frame begins on its rising edge (IDLE only)
//   mem_rd_en    one-cycle read strobe to the result memory
//   mem_rd_addr  element address 0..N-1, held between reads
//   mem_rd_data  read data, valid RD_LAT cycles after mem_rd_en
//   tx_busy      transmitter busy (high while shifting a byte)
//   tx_start     one-cycle pulse: tx_byte is valid, begin transmission
//   tx_byte      byte to transmit, stable from LOAD/HDR through ACK
//   busy         high from the cycle after the accepted start edge until done
//   done         one-cycle pulse after the last byte completes
//   byte_count   bytes fully transmitted in the current or last frame
//
// Transmitter handshake: tx_start pulses for one cycle only after tx_busy was
// seen low; the byte is then considered in flight until tx_busy has been seen
// high and has fallen low again, at which point it counts as transmitted.
// The FSM state is the internal signal 'state' for checkers to bind to.
module mat_stream_tx #(
  parameter int          ROWS        = 2,
  parameter int          COLS        = 2,
  parameter int          DATA_W      = 16,
  parameter int          ADDR_W      = 8,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter bit          HEADER_EN   = 1'b0,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5,
  parameter int          RD_LAT      = 1
) (
  input  logic              slow_clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_byte,
  output logic              busy,
  output logic              done,
  output logic [15:0]       byte_count
);

  localparam int N  = ROWS * COLS;
  localparam int NB = DATA_W / 8;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_RD, S_WAIT_RD, S_LOAD,
    S_SEND, S_ACK, S_WAIT_TX, S_NEXT, S_DONE
  } state_t;

  state_t             state;
  logic               start_q;
  logic               start_edge;
  logic               hdr_phase;   // the byte in flight is the header
  logic [ADDR_W-1:0]  elem_idx;
  logic [3:0]         byte_idx;
  logic [1:0]         lat_cnt;
  logic [DATA_W-1:0]  shreg;

  assign start_edge = start & ~start_q;

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      start_q     <= 1'b0;
      hdr_phase   <= 1'b0;
      elem_idx    <= '0;
      byte_idx    <= '0;
      lat_cnt     <= '0;
      shreg       <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      tx_start    <= 1'b0;
      tx_byte     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      byte_count  <= '0;
    end else begin
      // Tracked in every state so edges seen while busy (or during DONE)
      // are consumed rather than replayed once IDLE is reached.
      start_q <= start;
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            busy       <= 1'b1;
            byte_count <= '0;
            elem_idx   <= '0;
            byte_idx   <= '0;
            if (HEADER_EN) begin
              hdr_phase <= 1'b1;
              state     <= S_HDR;
            end else begin
              state <= S_RD;
            end
          end
        end
        S_HDR: begin
          tx_byte <= HEADER_BYTE;
          state   <= S_SEND;
        end
        S_RD: begin
          mem_rd_en   <= 1'b1;
          mem_rd_addr <= elem_idx;
          lat_cnt     <= '0;
          state       <= S_WAIT_RD;
        end
        S_WAIT_RD: begin
          // mem_rd_en is visible during the first WAIT_RD cycle (lat_cnt=0),
          // so the data is valid when lat_cnt reaches RD_LAT.
          mem_rd_en <= 1'b0;
          if (lat_cnt == 2'(RD_LAT)) begin
            shreg <= mem_rd_data;
            state <= S_LOAD;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        S_LOAD: begin
          tx_byte <= MSB_FIRST ? shreg[DATA_W-1 -: 8] : shreg[7:0];
          state   <= S_SEND;
        end
        S_SEND: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            state    <= S_ACK;
          end
        end
        S_ACK: begin
          tx_start <= 1'b0;
          if (tx_busy) state <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (!tx_busy) begin
            if (byte_count != 16'hFFFF) byte_count <= byte_count + 16'd1;
            if (hdr_phase) begin
              hdr_phase <= 1'b0;
              state     <= S_RD;
            end else begin
              state <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (byte_idx < 4'(NB - 1)) begin
            shreg    <= MSB_FIRST ? (shreg << 8) : (shreg >> 8);
            byte_idx <= byte_idx + 4'd1;
            state    <= S_LOAD;
          end else if (elem_idx < ADDR_W'(N - 1)) begin
            elem_idx <= elem_idx + 1'b1;
            byte_idx <= '0;
            state    <= S_RD;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
